// File: rtl/sys_defs.sv
// Shared datapath types for the CDB-side buffers.
// Widths here must match the rename/ROB configuration of the core.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package sys_defs;

    localparam int XLEN          = 32;
    localparam int PRN_WIDTH     = 6;
    localparam int ROB_IDX_WIDTH = 5;

    typedef logic [XLEN-1:0]          DATA;
    typedef logic [PRN_WIDTH-1:0]     PRN;
    typedef logic [ROB_IDX_WIDTH-1:0] ROB_IDX;
    typedef logic [`B_MASK_WIDTH-1:0] B_MASK;

    typedef struct packed {
        DATA    value;
        PRN     dest_prn;
        ROB_IDX rob_idx;
    } CDB_PACKET;

endpackage

// File: rtl/alu_cdb_buffer.sv
// In-order ALU result buffer feeding the CDB arbiter; results visible one cycle after capture.
// Backpressure: alu_ready drops when full, unless the head leaves this cycle (grant or squash skip).
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

module alu_cdb_buffer
    import sys_defs::*;
#(
    parameter int DEPTH        = 4,
    parameter int B_MASK_WIDTH = `B_MASK_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  DATA                     alu_result,
    input  PRN                      alu_dest_prn,
    input  ROB_IDX                  alu_rob_idx,
    input  logic [B_MASK_WIDTH-1:0] alu_b_mask,
    output logic                    alu_ready,
    input  logic                    b_resolve,
    input  logic                    b_squash,
    input  logic [B_MASK_WIDTH-1:0] b_tag,
    output logic                    cdb_valid,
    output CDB_PACKET               cdb_packet,
    input  logic                    cdb_grant
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [B_MASK_WIDTH-1:0] mask_t;

    typedef struct packed {
        logic   valid;
        logic   squashed;
        DATA    value;
        PRN     dest_prn;
        ROB_IDX rob_idx;
        mask_t  b_mask;
    } ALU_BUF_ENTRY;

    ALU_BUF_ENTRY       entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    ALU_BUF_ENTRY       head_entry;
    mask_t              resolve_clr;
    logic               full;
    logic               head_squashed;
    logic               head_kill;
    logic               grant_deq;
    logic               deq;
    logic               in_killed;
    logic               enq;

    always_comb begin
        head_entry    = entries[head];
        resolve_clr   = b_resolve ? b_tag : '0;
        full          = (count == (PTR_W+1)'(DEPTH));
        head_squashed = head_entry.valid && head_entry.squashed;
        // A squash landing on the head this cycle must not leak onto the bus.
        head_kill     = b_squash && |(head_entry.b_mask & b_tag);
        cdb_valid     = head_entry.valid && !head_entry.squashed && !head_kill;
        grant_deq     = cdb_valid && cdb_grant;
        deq           = grant_deq || head_squashed;
        alu_ready     = !full || grant_deq || head_squashed;
        in_killed     = b_squash && |(alu_b_mask & b_tag);
        enq           = alu_valid && alu_ready && !in_killed;
        cdb_packet    = '0;
        if (cdb_valid) begin
            cdb_packet.value    = head_entry.value;
            cdb_packet.dest_prn = head_entry.dest_prn;
            cdb_packet.rob_idx  = head_entry.rob_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid) begin
                    entries[i].b_mask <= entries[i].b_mask & ~resolve_clr;
                    if (b_squash && |(entries[i].b_mask & b_tag)) begin
                        entries[i].squashed <= 1'b1;
                    end
                end
            end
            if (deq) begin
                entries[head].valid <= 1'b0;
            end
            // When full, tail == head; the write must win over the dequeue clear.
            if (enq) begin
                entries[tail].valid    <= 1'b1;
                entries[tail].squashed <= 1'b0;
                entries[tail].value    <= alu_result;
                entries[tail].dest_prn <= alu_dest_prn;
                entries[tail].rob_idx  <= alu_rob_idx;
                entries[tail].b_mask   <= alu_b_mask & ~resolve_clr;
            end
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(enq);
            count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        end
    end

    resolve_squash_exclusive: assert property (
        @(posedge clock) disable iff (reset) !(b_resolve && b_squash)
    );

endmodule

// File: tb/tb_alu_cdb_buffer.sv
// Directed and random checks of alu_cdb_buffer against a queue-based reference model.
module tb_alu_cdb_buffer;
    import sys_defs::*;

    localparam int DEPTH = 4;

    logic      clock = 1'b0;
    logic      reset;
    logic      alu_valid;
    DATA       alu_result;
    PRN        alu_dest_prn;
    ROB_IDX    alu_rob_idx;
    logic [3:0] alu_b_mask;
    logic      alu_ready;
    logic      b_resolve;
    logic      b_squash;
    logic [3:0] b_tag;
    logic      cdb_valid;
    CDB_PACKET cdb_packet;
    logic      cdb_grant;

    alu_cdb_buffer #(.DEPTH(DEPTH), .B_MASK_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_result  (alu_result),
        .alu_dest_prn(alu_dest_prn),
        .alu_rob_idx (alu_rob_idx),
        .alu_b_mask  (alu_b_mask),
        .alu_ready   (alu_ready),
        .b_resolve   (b_resolve),
        .b_squash    (b_squash),
        .b_tag       (b_tag),
        .cdb_valid   (cdb_valid),
        .cdb_packet  (cdb_packet),
        .cdb_grant   (cdb_grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] v;
        logic [5:0]  p;
        logic [4:0]  r;
        logic [3:0]  m;
        bit          sq;
    } ref_t;

    ref_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle's outputs, then advances the model across the coming edge.
    task automatic model_step();
        bit        cv;
        bit        hsq;
        bit        rdy;
        CDB_PACKET pk;
        cv  = 0;
        hsq = 0;
        pk  = '0;
        if (q.size() > 0) begin
            hsq = q[0].sq;
            cv  = !q[0].sq && !(b_squash && ((q[0].m & b_tag) != 4'd0));
            if (cv) begin
                pk.value    = q[0].v;
                pk.dest_prn = q[0].p;
                pk.rob_idx  = q[0].r;
            end
        end
        rdy = (q.size() < DEPTH) || (cv && cdb_grant) || hsq;
        chk("count", 64'(dut.count), 64'(q.size()));
        chk("cdb_valid", 64'(cdb_valid), 64'(cv));
        chk("cdb_packet", 64'(cdb_packet), 64'(pk));
        chk("alu_ready", 64'(alu_ready), 64'(rdy));
        if ((cv && cdb_grant) || hsq) begin
            void'(q.pop_front());
        end
        foreach (q[i]) begin
            if (b_resolve) q[i].m = q[i].m & ~b_tag;
            if (b_squash && ((q[i].m & b_tag) != 4'd0)) q[i].sq = 1;
        end
        if (alu_valid && rdy && !(b_squash && ((alu_b_mask & b_tag) != 4'd0))) begin
            q.push_back('{alu_result, alu_dest_prn, alu_rob_idx,
                          b_resolve ? (alu_b_mask & ~b_tag) : alu_b_mask, 1'b0});
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] res, input logic [5:0] prn,
                         input logic [4:0] rob, input logic [3:0] m, input bit g,
                         input bit rs, input bit sq, input logic [3:0] tag);
        @(negedge clock);
        alu_valid    = v;
        alu_result   = res;
        alu_dest_prn = prn;
        alu_rob_idx  = rob;
        alu_b_mask   = m;
        cdb_grant    = g;
        b_resolve    = rs;
        b_squash     = sq;
        b_tag        = tag;
        #1;
        model_step();
    endtask

    task automatic idle(input bit g);
        drive(0, 32'd0, 6'd0, 5'd0, 4'd0, g, 0, 0, 4'd0);
    endtask

    task automatic do_reset(input bit g);
        @(negedge clock);
        reset     = 1'b1;
        alu_valid = 1'b1;
        cdb_grant = g;
        b_resolve = 1'b0;
        b_squash  = 1'b0;
        @(negedge clock);
        reset     = 1'b0;
        alu_valid = 1'b0;
        cdb_grant = 1'b0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        CDB_PACKET exp_pk;
        int        pulses;
        int        pulse_at;
        logic [31:0] pulse_val;

        reset = 1'b1; alu_valid = 0; alu_result = '0; alu_dest_prn = '0; alu_rob_idx = '0;
        alu_b_mask = '0; b_resolve = 0; b_squash = 0; b_tag = '0; cdb_grant = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        idle(0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_packet", 64'(cdb_packet), 64'd0);

        // Single result, minimum latency, grant held
        drive(1, 32'h0000_0005, 6'd7, 5'd3, 4'd0, 1, 0, 0, 4'd0);
        chk("lat_same_cycle", 64'(cdb_valid), 64'd0);
        idle(1);
        exp_pk = '{32'h5, 6'd7, 5'd3};
        chk("lat_valid", 64'(cdb_valid), 64'd1);
        chk("lat_packet", 64'(cdb_packet), 64'(exp_pk));
        idle(1);
        chk("lat_gone", 64'(cdb_valid), 64'd0);

        // Fill, then enqueue + dequeue while full
        for (int i = 0; i < 4; i++) drive(1, 32'(100 + i), 6'(10 + i), 5'(i), 4'd0, 0, 0, 0, 4'd0);
        idle(0);
        chk("full_ready", 64'(alu_ready), 64'd0);
        chk("full_count", 64'(dut.count), 64'd4);
        drive(1, 32'd104, 6'd14, 5'd4, 4'd0, 1, 0, 0, 4'd0);
        chk("full_bypass_ready", 64'(alu_ready), 64'd1);
        chk("full_head_val", 64'(cdb_packet.value), 64'd100);
        idle(0);
        chk("full_count_kept", 64'(dut.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            chk("order_val", 64'(cdb_packet.value), 64'(100 + i));
        end
        idle(0);
        chk("drained", 64'(dut.count), 64'd0);

        // Squash with mixed masks
        drive(1, 32'd200, 6'd20, 5'd8, 4'b0001, 0, 0, 0, 4'd0);
        drive(1, 32'd201, 6'd21, 5'd9, 4'b0010, 0, 0, 0, 4'd0);
        drive(1, 32'd202, 6'd22, 5'd10, 4'b0001, 0, 0, 0, 4'd0);
        drive(0, 32'd0, 6'd0, 5'd0, 4'd0, 0, 0, 1, 4'b0001);
        chk("sq_same_cycle", 64'(cdb_valid), 64'd0);
        pulses = 0; pulse_at = -1; pulse_val = '0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            if (cdb_valid) begin
                pulses++;
                pulse_at  = i;
                pulse_val = cdb_packet.value;
            end
        end
        chk("sq_pulses", 64'(pulses), 64'd1);
        chk("sq_pulse_cycle", 64'(pulse_at), 64'd1);
        chk("sq_pulse_val", 64'(pulse_val), 64'd201);
        chk("sq_count", 64'(dut.count), 64'd0);

        // Resolve then squash of the same tag
        drive(1, 32'd300, 6'd30, 5'd11, 4'b0100, 0, 0, 0, 4'd0);
        drive(0, 32'd0, 6'd0, 5'd0, 4'd0, 0, 1, 0, 4'b0100);
        drive(0, 32'd0, 6'd0, 5'd0, 4'd0, 0, 0, 1, 4'b0100);
        chk("rs_valid", 64'(cdb_valid), 64'd1);
        chk("rs_mask", 64'(dut.entries[dut.head].b_mask), 64'd0);
        idle(1);
        idle(0);
        chk("rs_count", 64'(dut.count), 64'd0);

        // Incoming result killed by a same-cycle squash
        drive(1, 32'd400, 6'd40, 5'd12, 4'b1000, 0, 0, 1, 4'b1000);
        chk("kill_ready", 64'(alu_ready), 64'd1);
        idle(0);
        chk("kill_valid", 64'(cdb_valid), 64'd0);
        chk("kill_count", 64'(dut.count), 64'd0);

        // Mid-operation reset with grant asserted
        for (int i = 0; i < 3; i++) drive(1, 32'(500 + i), 6'(50 + i), 5'(13 + i), 4'd0, 0, 0, 0, 4'd0);
        do_reset(1);
        idle(0);
        chk("mrst_valid", 64'(cdb_valid), 64'd0);
        chk("mrst_ready", 64'(alu_ready), 64'd1);
        chk("mrst_count", 64'(dut.count), 64'd0);
        drive(1, 32'd600, 6'd60, 5'd20, 4'd0, 0, 0, 0, 4'd0);
        idle(0);
        chk("mrst_slot0_valid", 64'(dut.entries[0].valid), 64'd1);
        chk("mrst_slot0_val", 64'(dut.entries[0].value), 64'd600);
        chk("mrst_head_val", 64'(cdb_packet.value), 64'd600);
        idle(1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            int  ev;
            bit  g;
            ev = int'($urandom_range(0, 9));
            g  = (n < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive(bit'($urandom_range(0, 1)), $urandom, 6'($urandom), 5'($urandom),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)), g,
                  ev == 0, ev == 1, 4'(1 << $urandom_range(0, 3)));
        end
        repeat (8) idle(1);
        idle(0);
        chk("final_count", 64'(dut.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cdb_buffer.md
Name: alu_cdb_buffer

Overview:
Sits between one ALU functional unit and the common data bus (CDB) arbiter.
- Captures each completed ALU result: value, destination physical register, ROB index and branch mask.
- Holds results in order in a small FIFO until the CDB grants a broadcast.
- Applies branch-resolve and branch-squash updates to every held entry, so no wrong-path result reaches the CDB.
- Back-pressures the ALU issue stage when full.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
B_MASK_WIDTH, `B_MASK_WIDTH (package constant, 4), width of the branch mask and branch tag.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result valid this cycle
alu_result  in  DATA (32)  ALU output value
alu_dest_prn  in  PRN  destination physical register
alu_rob_idx  in  ROB_IDX  ROB entry of the instruction
alu_b_mask  in  B_MASK  branch dependencies of the instruction
alu_ready  out  1  buffer can accept a result this cycle
b_resolve  in  1  a branch resolved as correctly predicted
b_squash  in  1  a branch resolved as mispredicted
b_tag  in  B_MASK  one-hot tag of the resolving branch
cdb_valid  out  1  head entry requests the CDB
cdb_packet  out  CDB_PACKET  {value, dest_prn, rob_idx} of the head entry
cdb_grant  in  1  arbiter accepts the head this cycle

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - All entries are invalid, head = tail = 0, count = 0.
  - cdb_valid = 0, alu_ready = 1 in the first cycle after reset.
  - cdb_packet = 0 while cdb_valid = 0.
  - Reset mid-operation drops every entry; a grant in the reset cycle has no effect.
- Per-entry state: {valid, squashed, DATA, PRN, ROB_IDX, B_MASK}.
- Enqueue:
  - Happens when alu_valid && alu_ready; the entry is written at tail and tail advances.
  - Minimum latency: an entry is visible on cdb_valid the next cycle. There is no combinational bypass.
- alu_ready:
  - alu_ready = !full || (cdb_valid && cdb_grant) || head_squashed.
  - This is a combinational path from cdb_grant; the arbiter drives grant from registered state.
- Dequeue:
  - On cdb_valid && cdb_grant, head advances.
  - If the head entry is squashed, head advances unconditionally, one entry per cycle, with cdb_valid = 0.
- cdb_valid = head entry valid && !squashed && !(b_squash && |(head.b_mask & b_tag)).
  - A same-cycle squash suppresses the request.
- b_resolve:
  - Clears the b_tag bit in every stored mask.
  - Also clears it in the mask of a same-cycle incoming enqueue.
- b_squash:
  - Marks squashed every stored entry whose mask & b_tag != 0.
  - An incoming enqueue whose mask matches is dropped: not written, tail unchanged, alu_ready unaffected.
- b_resolve and b_squash are never asserted together; assert this in simulation.
- Full / empty:
  - count == DEPTH means full.
  - Enqueue and dequeue in the same cycle when full is legal; count stays unchanged.
  - Enqueue when empty is legal.
  - A grant with cdb_valid = 0 is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Order: results leave in arrival order. Squashed entries are removed only from the head.

Decomposition:
- Shared package (sys_defs): DATA, PRN, ROB_IDX, B_MASK, `B_MASK_WIDTH, and CDB_PACKET {value, dest_prn, rob_idx}.
- Local to the module: the typedef ALU_BUF_ENTRY.
- No sub-module. The FIFO is inline because the per-entry mask update needs all-entry access.

Test Plan:
- Reset, then alu_valid = 1 with result 32'h0000_0005, prn 7, rob 3, and cdb_grant held 1 -> next cycle cdb_valid = 1 with packet {5, 7, 3}; the following cycle cdb_valid = 0.
- 4 enqueues with cdb_grant = 0 -> alu_ready = 0 after the 4th. A 5th alu_valid plus cdb_grant = 1 in the same cycle -> the head dequeues, the 5th is accepted, count stays 4, order is preserved.
- Entries with masks 4'b0001, 4'b0010, 4'b0001, then b_squash with b_tag 4'b0001 -> entries 0 and 2 are never broadcast; the entry with mask 4'b0010 is the only cdb_valid pulse, with the squashed head skipped in 1 cycle.
- Entry with mask 4'b0100, then b_resolve with b_tag 4'b0100, then b_squash with b_tag 4'b0100 -> the entry is still broadcast; its stored mask is 0.
- Same-cycle alu_valid with mask 4'b1000 and b_squash with b_tag 4'b1000 -> not enqueued, count unchanged, no cdb_valid.
- 3 entries held, reset asserted for 1 cycle -> cdb_valid = 0, alu_ready = 1, count = 0; a new enqueue afterwards appears at slot 0.
